// File: rtl/etpu_dbg_pkg.sv
// etpu_dbg_pkg: shared state encoding, counter width and geometry helpers
// for the debug-output serializer.
package etpu_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } dbg_state_e;

    localparam int DROP_CNT_W = 8;

    // Number of LANES-wide beats needed to carry one word.
    function automatic int beats(input int word_w, input int lanes);
        return word_w / lanes;
    endfunction

    // Counter width able to index n items (never narrower than one bit).
    function automatic int ctr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Legal geometry: 1..8 lanes and a word that splits into whole beats.
    function automatic bit geometry_ok(input int word_w, input int lanes);
        return (lanes >= 1) && (lanes <= 8) && (word_w >= lanes) &&
               ((word_w % lanes) == 0);
    endfunction

endpackage

// File: rtl/etpu_dbg_fifo.sv
// etpu_dbg_fifo: synchronous FIFO holding queued debug words.
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate occupancy register. Pushes while full and pops while
// empty are ignored.
module etpu_dbg_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("etpu_dbg_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count   = wptr - rptr;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    // Storage array: written on accepted pushes only, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    // Read/write pointers; reset empties the queue.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/etpu_dbg_serializer.sv
// etpu_dbg_serializer: queues 32-bit debug words and shifts them out
// LANES bits per cycle, LSB chunk first, framed by dbg_active/dbg_first.
// Optional feature macro: ETPU_DBG_PARITY_EN appends one parity beat per
// word (dbg_data[0] = XOR of the word, upper lanes zero).
module etpu_dbg_serializer
    import etpu_dbg_pkg::*;
#(
    parameter int WORD_W       = 32,
    parameter int LANES        = 4,
    parameter int DEPTH        = 4,
    parameter int DROP_ON_FULL = 0
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  enable,
    input  logic [WORD_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  dbg_active,
    output logic                  dbg_first,
    output logic [LANES-1:0]      dbg_data,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int BEATS = beats(WORD_W, LANES);
    localparam int BW    = ctr_w(BEATS);
    localparam int CW    = $clog2(DEPTH) + 1;

    if (!geometry_ok(WORD_W, LANES)) begin : g_bad_geometry
        $error("etpu_dbg_serializer: LANES must be 1..8 and divide WORD_W");
    end

    dbg_state_e        state;
    logic [BW-1:0]     beat;
    logic [WORD_W-1:0] sr;
    logic [WORD_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              fifo_push;
    logic              at_capacity;
    logic              drop_evt;
    logic              last_beat;
    logic              slot_free;
    logic              pop;
`ifdef ETPU_DBG_PARITY_EN
    logic              par_bit;
`endif

    // Lossy mode always accepts; overflow is counted instead of refused.
    assign in_ready    = (DROP_ON_FULL != 0) ? 1'b1 : !fifo_full;
    assign at_capacity = (fifo_count == CW'(DEPTH));
    assign fifo_push   = in_valid && in_ready && !at_capacity;
    assign drop_evt    = (DROP_ON_FULL != 0) && in_valid && at_capacity;
    assign last_beat   = (beat == BW'(BEATS - 1));
    assign pop         = slot_free && !fifo_empty && enable;

    etpu_dbg_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetb (resetb),
        .push   (fifo_push),
        .wdata  (in_data),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Decide whether the current cycle ends a frame so a new word may load.
    always_comb begin
        slot_free = 1'b0;
        case (state)
            ST_IDLE:   slot_free = 1'b1;
`ifdef ETPU_DBG_PARITY_EN
            ST_PARITY: slot_free = 1'b1;
`else
            ST_SHIFT:  slot_free = last_beat;
`endif
            default:   slot_free = 1'b0;
        endcase
    end

    // Frame FSM: loads the head word, walks its beats, optionally appends
    // parity. Beat 0 is presented straight from the FIFO head on the pop
    // edge, so the shift register holds only the not-yet-sent beats.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state      <= ST_IDLE;
            beat       <= '0;
            sr         <= '0;
            dbg_active <= 1'b0;
            dbg_first  <= 1'b0;
            dbg_data   <= '0;
`ifdef ETPU_DBG_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else if (pop) begin
            state      <= ST_SHIFT;
            beat       <= '0;
            sr         <= fifo_rdata >> LANES;
            dbg_active <= 1'b1;
            dbg_first  <= 1'b1;
            dbg_data   <= fifo_rdata[LANES-1:0];
`ifdef ETPU_DBG_PARITY_EN
            par_bit    <= ^fifo_rdata;
`endif
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (last_beat) begin
`ifdef ETPU_DBG_PARITY_EN
                        state      <= ST_PARITY;
                        dbg_active <= 1'b1;
                        dbg_first  <= 1'b0;
                        dbg_data   <= LANES'(par_bit);
`else
                        state      <= ST_IDLE;
                        dbg_active <= 1'b0;
                        dbg_first  <= 1'b0;
                        dbg_data   <= '0;
`endif
                    end else begin
                        beat      <= beat + BW'(1);
                        sr        <= sr >> LANES;
                        dbg_first <= 1'b0;
                        dbg_data  <= sr[LANES-1:0];
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    dbg_active <= 1'b0;
                    dbg_first  <= 1'b0;
                    dbg_data   <= '0;
                end
            endcase
        end
    end

    // Saturating count of words discarded in lossy mode.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            drop_cnt <= '0;
        end else if (drop_evt && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_etpu_dbg_serializer.sv
// Directed bench for etpu_dbg_serializer: instance A in back-pressure mode,
// instance B in lossy mode, sharing clock and reset.
module tb_etpu_dbg_serializer;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;
    localparam int DEPTH  = 4;
    localparam int BEATS  = 8;
`ifdef ETPU_DBG_PARITY_EN
    localparam int FRAME  = BEATS + 1;
`else
    localparam int FRAME  = BEATS;
`endif

    logic              clk    = 1'b0;
    logic              resetb = 1'b0;

    logic              en_a    = 1'b0;
    logic              valid_a = 1'b0;
    logic [WORD_W-1:0] data_a  = '0;
    logic              ready_a;
    logic              act_a;
    logic              first_a;
    logic [LANES-1:0]  dout_a;
    logic [7:0]        drop_a;

    logic              en_b    = 1'b0;
    logic              valid_b = 1'b0;
    logic [WORD_W-1:0] data_b  = '0;
    logic              ready_b;
    logic              act_b;
    logic              first_b;
    logic [LANES-1:0]  dout_b;
    logic [7:0]        drop_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    etpu_dbg_serializer #(
        .WORD_W       (WORD_W),
        .LANES        (LANES),
        .DEPTH        (DEPTH),
        .DROP_ON_FULL (0)
    ) dut_a (
        .clk        (clk),
        .resetb     (resetb),
        .enable     (en_a),
        .in_data    (data_a),
        .in_valid   (valid_a),
        .in_ready   (ready_a),
        .dbg_active (act_a),
        .dbg_first  (first_a),
        .dbg_data   (dout_a),
        .drop_cnt   (drop_a)
    );

    etpu_dbg_serializer #(
        .WORD_W       (WORD_W),
        .LANES        (LANES),
        .DEPTH        (DEPTH),
        .DROP_ON_FULL (1)
    ) dut_b (
        .clk        (clk),
        .resetb     (resetb),
        .enable     (en_b),
        .in_data    (data_b),
        .in_valid   (valid_b),
        .in_ready   (ready_b),
        .dbg_active (act_b),
        .dbg_first  (first_b),
        .dbg_data   (dout_b),
        .drop_cnt   (drop_b)
    );

    function automatic logic [WORD_W-1:0] tw(input int i);
        return 32'h0F1E2D3C + 32'h11111111 * 32'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] obs;
        resetb = 1'b0;
        tick();
        tick();
        n_cmp++;
        obs = {24'd0, ready_a, ready_b, act_a, act_b, first_a, first_b, 2'b00};
        if (obs !== 32'h0000_00C0) begin
            n_bad++;
            $display("FAIL reset_held: got %h expected %h", obs, 32'h0000_00C0);
        end
        resetb = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_cmp++;
            if ({ready_a, ready_b, act_a, act_b, first_a, first_b, dout_a, dout_b, drop_a, drop_b}
                !== {2'b11, 4'b0000, 8'h00, 16'h0000}) begin
                n_bad++;
                $display("FAIL reset_idle cyc %0d: rdy %b%b act %b%b first %b%b data %h/%h drop %0d/%0d expected rdy 11, rest 0",
                         c, ready_a, ready_b, act_a, act_b, first_a, first_b, dout_a, dout_b, drop_a, drop_b);
            end
        end
    endtask

    task automatic test_single_word();
        en_a    = 1'b1;
        valid_a = 1'b1;
        data_a  = 32'h87654321;
        tick();                 // handshake edge E0
        valid_a = 1'b0;
        n_cmp++;
        if (act_a !== 1'b0) begin
            n_bad++;
            $display("FAIL single_latency: act %b one cycle after push, expected 0", act_a);
        end
        for (int k = 0; k < BEATS; k++) begin
            tick();
            n_cmp++;
            if ({act_a, first_a, dout_a} !== {1'b1, (k == 0), 4'(k + 1)}) begin
                n_bad++;
                $display("FAIL single_beat%0d: act %b first %b data %h expected 1 %b %h",
                         k + 1, act_a, first_a, dout_a, (k == 0), 4'(k + 1));
            end
        end
`ifdef ETPU_DBG_PARITY_EN
        tick();
        n_cmp++;
        if ({act_a, first_a, dout_a} !== {1'b1, 1'b0, 4'b0001}) begin
            n_bad++;
            $display("FAIL single_parity: act %b first %b data %h expected 1 0 1", act_a, first_a, dout_a);
        end
`endif
        tick();
        n_cmp++;
        if ({act_a, first_a, dout_a} !== 6'b0) begin
            n_bad++;
            $display("FAIL single_end: act %b first %b data %h expected all 0", act_a, first_a, dout_a);
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int run = 0;
        int best = 0;
        int runs = 0;
        int full_at = -1;
        int k = 0;
        logic hs;
        logic [WORD_W-1:0] cur = '0;
        logic [WORD_W-1:0] got[$];
        en_a    = 1'b1;
        valid_a = 1'b1;
        data_a  = tw(0);
        for (int c = 0; c < 80; c++) begin
            hs = valid_a && ready_a;
            tick();
            if (hs) idx++;
            if (idx < 6) data_a = tw(idx);
            else valid_a = 1'b0;
            if (!ready_a && full_at < 0) full_at = idx;
            if (act_a) begin
                if (run == 0) runs++;
                run++;
                if (run > best) best = run;
                if (first_a) begin
                    k   = 0;
                    cur = '0;
                end
                if (k < BEATS) cur[k*LANES +: LANES] = dout_a;
                if (k == BEATS - 1) got.push_back(cur);
                k++;
            end else begin
                run = 0;
            end
        end
        valid_a = 1'b0;
        n_cmp++;
        if (full_at !== 5) begin
            n_bad++;
            $display("FAIL b2b_ready_fall: in_ready fell after %0d accepted words, expected 5", full_at);
        end
        n_cmp++;
        if (idx !== 6) begin
            n_bad++;
            $display("FAIL b2b_accepted: %0d words accepted, expected 6", idx);
        end
        n_cmp++;
        if (best !== 6 * FRAME || runs !== 1) begin
            n_bad++;
            $display("FAIL b2b_no_gap: longest run %0d in %0d runs, expected %0d in 1", best, runs, 6 * FRAME);
        end
        n_cmp++;
        if (got.size() !== 6) begin
            n_bad++;
            $display("FAIL b2b_count: %0d words captured, expected 6", got.size());
        end
        for (int i = 0; i < 6; i++) begin
            if (i < got.size()) begin
                n_cmp++;
                if (got[i] !== tw(i)) begin
                    n_bad++;
                    $display("FAIL b2b_word%0d: got %h expected %h", i, got[i], tw(i));
                end
            end
        end
    endtask

    task automatic test_lossy();
        int k = 0;
        int not_ready = 0;
        logic [WORD_W-1:0] cur = '0;
        logic [WORD_W-1:0] got[$];
        en_b    = 1'b1;
        valid_b = 1'b1;
        data_b  = tw(0);
        for (int c = 0; c < 120; c++) begin
            if (!ready_b) not_ready++;
            tick();
            if (c < 9) data_b = tw(c + 1);
            else valid_b = 1'b0;
            if (act_b) begin
                if (first_b) begin
                    k   = 0;
                    cur = '0;
                end
                if (k < BEATS) cur[k*LANES +: LANES] = dout_b;
                if (k == BEATS - 1) got.push_back(cur);
                k++;
            end
        end
        n_cmp++;
        if (not_ready !== 0) begin
            n_bad++;
            $display("FAIL lossy_ready: in_ready low on %0d cycles, expected 0", not_ready);
        end
        n_cmp++;
        if (drop_b !== 8'd5) begin
            n_bad++;
            $display("FAIL lossy_drop5: drop_cnt %0d expected 5", drop_b);
        end
        n_cmp++;
        if (got.size() !== 5) begin
            n_bad++;
            $display("FAIL lossy_count: %0d words delivered, expected 5", got.size());
        end
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) begin
                n_cmp++;
                if (got[i] !== tw(i)) begin
                    n_bad++;
                    $display("FAIL lossy_word%0d: got %h expected %h", i, got[i], tw(i));
                end
            end
        end
        // Hold the FIFO full with enable low, then drop 300 more words.
        en_b    = 1'b0;
        valid_b = 1'b1;
        for (int c = 0; c < 4 + 249; c++) tick();
        n_cmp++;
        if (drop_b !== 8'd254) begin
            n_bad++;
            $display("FAIL lossy_drop254: drop_cnt %0d expected 254", drop_b);
        end
        tick();
        n_cmp++;
        if (drop_b !== 8'd255) begin
            n_bad++;
            $display("FAIL lossy_drop255: drop_cnt %0d expected 255", drop_b);
        end
        for (int c = 0; c < 50; c++) tick();
        n_cmp++;
        if (drop_b !== 8'd255 || ready_b !== 1'b1) begin
            n_bad++;
            $display("FAIL lossy_saturate: drop_cnt %0d ready %b expected 255 1", drop_b, ready_b);
        end
        valid_b = 1'b0;
    endtask

`ifdef ETPU_DBG_PARITY_EN
    task automatic test_parity();
        logic [3:0] exp_p[2];
        logic [WORD_W-1:0] w[2];
        w[0] = 32'h00000001;
        w[1] = 32'h00000003;
        exp_p[0] = 4'b0001;
        exp_p[1] = 4'b0000;
        en_a = 1'b1;
        for (int t = 0; t < 2; t++) begin
            valid_a = 1'b1;
            data_a  = w[t];
            tick();
            valid_a = 1'b0;
            tick();
            n_cmp++;
            if ({act_a, first_a, dout_a} !== {2'b11, w[t][3:0]}) begin
                n_bad++;
                $display("FAIL parity%0d_beat1: act %b first %b data %h expected 1 1 %h",
                         t, act_a, first_a, dout_a, w[t][3:0]);
            end
            for (int k = 1; k < BEATS; k++) tick();
            tick();
            n_cmp++;
            if ({act_a, first_a, dout_a} !== {2'b10, exp_p[t]}) begin
                n_bad++;
                $display("FAIL parity%0d_beat9: act %b first %b data %h expected 1 0 %h",
                         t, act_a, first_a, dout_a, exp_p[t]);
            end
            tick();
            n_cmp++;
            if (act_a !== 1'b0) begin
                n_bad++;
                $display("FAIL parity%0d_end: act %b expected 0", t, act_a);
            end
        end
    endtask
`endif

    task automatic test_reset_mid_word();
        int seen = 0;
        logic [WORD_W-1:0] w0;
        w0 = tw(0);
        en_a    = 1'b1;
        valid_a = 1'b1;
        data_a  = tw(0);
        tick();
        data_a  = tw(1);
        tick();
        data_a  = tw(2);
        tick();
        valid_a = 1'b0;
        tick();                 // beat 3 of word 0 on the pins, 2 words queued
        n_cmp++;
        if ({act_a, dout_a} !== {1'b1, w0[11:8]}) begin
            n_bad++;
            $display("FAIL rst_pre_beat3: act %b data %h expected 1 %h", act_a, dout_a, w0[11:8]);
        end
        resetb = 1'b0;
        #1;
        n_cmp++;
        if ({act_a, first_a, dout_a, drop_b, ready_a} !== {14'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL rst_async: act %b first %b data %h drop_b %0d ready %b expected 0 0 0 0 1",
                     act_a, first_a, dout_a, drop_b, ready_a);
        end
        en_b = 1'b1;
        tick();
        tick();
        resetb = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (act_a || act_b) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL rst_fifo_lost: %0d active cycles after reset, expected 0", seen);
        end
        n_cmp++;
        if (drop_b !== 8'd0 || drop_a !== 8'd0) begin
            n_bad++;
            $display("FAIL rst_drop_cnt: drop_cnt %0d/%0d expected 0/0", drop_a, drop_b);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_lossy();
`ifdef ETPU_DBG_PARITY_EN
        test_parity();
`endif
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
